// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ==========================================================================
// mem_ctrl_pkg : shared encodings for the data-RAM access controller
// Rev 1.0
// ==========================================================================
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [1:0] SIZE_BYTE   = 2'b00;
  localparam logic [1:0] SIZE_WORD   = 2'b10;
  localparam logic       GRANT_FETCH = 1'b0;
  localparam logic       GRANT_DATA  = 1'b1;
  localparam logic       RW_READ     = 1'b1;
  localparam logic       RW_WRITE    = 1'b0;

  // Any size code other than byte is a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == SIZE_BYTE) ? SIZE_BYTE : SIZE_WORD;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_counter.sv
`default_nettype none
// ==========================================================================
// mem_wait_counter : loadable up-counter, flags the final RAM access cycle
// Rev 1.0
// ==========================================================================
module mem_wait_counter #(
  parameter int WAIT_STATES = 2,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic last
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign last = (cnt_q == CNT_W'(WAIT_STATES));

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en && !last) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_controller.sv
`default_nettype none
// ==========================================================================
// mem_access_controller : arbitrates fetch/data requesters onto one RAM port
// Optional macro ARB_ROUND_ROBIN_EN selects alternating collision arbitration.
// Rev 1.0
// ==========================================================================
module mem_access_controller
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_moc,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_moc,
  output logic              ram_en,
  output logic              ram_rw,
  output logic [1:0]        ram_size,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              rw_q, rw_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              cnt_last;
  logic              data_wins;
  logic              in_access;
  logic              in_done;
  logic [1:0]        d_size_n;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;
  assign data_wins = (last_grant_q == GRANT_FETCH);
`else
  assign data_wins = 1'b1;
`endif

  assign d_size_n  = norm_size(d_size);
  assign in_access = (state_q == ST_ACCESS);
  assign in_done   = (state_q == ST_DONE);

  mem_wait_counter #(
    .WAIT_STATES (WAIT_STATES),
    .CNT_W       (4)
  ) u_wait_counter (
    .clk   (clk),
    .reset (reset),
    .load  (state_q == ST_IDLE),
    .en    (in_access),
    .last  (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rw_d    = rw_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (f_req || d_req) begin
          state_d = ST_ACCESS;
          if (d_req && (!f_req || data_wins)) begin
            grant_d = GRANT_DATA;
            rw_d    = d_rw;
            size_d  = d_size_n;
            if (d_size_n == SIZE_BYTE) begin
              addr_d  = d_addr;
              wdata_d = {{(DATA_W-8){1'b0}}, d_wdata[7:0]};
            end else begin
              addr_d  = d_addr & WORD_MASK;
              wdata_d = d_wdata;
            end
          end else begin
            grant_d = GRANT_FETCH;
            rw_d    = RW_READ;
            size_d  = SIZE_WORD;
            addr_d  = f_addr & WORD_MASK;
            wdata_d = '0;
          end
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = grant_d;
`endif
        end
      end
      ST_ACCESS: begin
        // RAM read data is only valid on the final access cycle.
        if (cnt_last) begin
          if (size_q == SIZE_BYTE) begin
            rdata_d = {{(DATA_W-8){1'b0}}, ram_rdata[7:0]};
          end else begin
            rdata_d = ram_rdata;
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!((grant_q == GRANT_DATA) ? d_req : f_req)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      grant_q <= GRANT_FETCH;
      rw_q    <= RW_WRITE;
      size_q  <= SIZE_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= GRANT_FETCH;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // RAM command is driven only while the access is in flight.
  assign ram_en    = in_access;
  assign ram_rw    = in_access & rw_q;
  assign ram_size  = in_access ? size_q  : 2'b00;
  assign ram_addr  = in_access ? addr_q  : '0;
  assign ram_wdata = in_access ? wdata_q : '0;

  assign f_moc   = in_done && (grant_q == GRANT_FETCH);
  assign d_moc   = in_done && (grant_q == GRANT_DATA);
  assign f_rdata = f_moc ? rdata_q : '0;
  assign d_rdata = d_moc ? rdata_q : '0;
  assign busy    = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_access_controller.sv
`default_nettype none
// ==========================================================================
// tb_mem_access_controller : directed scoreboard bench with a byte RAM model
// Rev 1.0
// ==========================================================================
module tb_mem_access_controller;

  localparam int WS     = 2;
  localparam int BUDGET = 40;

  logic        clk;
  logic        reset;
  logic        f_req;
  logic [7:0]  f_addr;
  logic [31:0] f_rdata;
  logic        f_moc;
  logic        d_req;
  logic        d_rw;
  logic [1:0]  d_size;
  logic [7:0]  d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_moc;
  logic        ram_en;
  logic        ram_rw;
  logic [1:0]  ram_size;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        busy;

  typedef struct {
    bit          is_data;
    bit          rw;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] mem [0:255];

  mem_access_controller #(
    .ADDR_W      (8),
    .DATA_W      (32),
    .WAIT_STATES (WS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_rdata   (f_rdata),
    .f_moc     (f_moc),
    .d_req     (d_req),
    .d_rw      (d_rw),
    .d_size    (d_size),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_moc     (d_moc),
    .ram_en    (ram_en),
    .ram_rw    (ram_rw),
    .ram_size  (ram_size),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian byte RAM; byte reads also return neighbouring bytes so the
  // controller's zero-extension is exercised.
  assign ram_rdata = {mem[ram_addr + 8'd3], mem[ram_addr + 8'd2],
                      mem[ram_addr + 8'd1], mem[ram_addr]};

  always @(posedge clk) begin
    if (ram_en && !ram_rw) begin
      mem[ram_addr] <= ram_wdata[7:0];
      if (ram_size != 2'b00) begin
        mem[ram_addr + 8'd1] <= ram_wdata[15:8];
        mem[ram_addr + 8'd2] <= ram_wdata[23:16];
        mem[ram_addr + 8'd3] <= ram_wdata[31:24];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, " moc on granted port"}, {31'd0, e.is_data ? d_moc : f_moc}, 32'd1);
      chk({tag, " no moc on other port"}, {31'd0, e.is_data ? f_moc : d_moc}, 32'd0);
      if (e.rw) begin
        chk({tag, " rdata"}, e.is_data ? d_rdata : f_rdata, e.rdata);
      end
    end
  endtask

  task automatic wait_moc(input int budget, output bit got, output int cyc);
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (f_moc || d_moc) got = 1'b1;
    end
  endtask

  // Called at a negedge: issues one request, checks the RAM command on every
  // access cycle, the latency, the returned data, the hold phase and the release.
  task automatic access(input string tag, input bit is_data, input bit rw,
                        input logic [1:0] size, input logic [7:0] addr,
                        input logic [31:0] wdata, input logic [7:0] exp_addr,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                        input int hold);
    int cyc = 0;
    int en_cnt = 0;
    bit got = 1'b0;
    if (is_data) begin
      d_req = 1'b1; d_rw = rw; d_size = size; d_addr = addr; d_wdata = wdata;
    end else begin
      f_req = 1'b1; f_addr = addr;
    end
    sb.push_back('{is_data, rw, exp_rdata});
    while (!got && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (ram_en) begin
        en_cnt++;
        chk({tag, " ram_addr"}, {24'd0, ram_addr}, {24'd0, exp_addr});
        chk({tag, " ram_rw"}, {31'd0, ram_rw}, {31'd0, rw});
        chk({tag, " ram_size"}, {30'd0, ram_size}, {30'd0, (size == 2'b00) ? 2'b00 : 2'b10});
        if (!rw) chk({tag, " ram_wdata"}, ram_wdata, exp_wdata);
        // Later input changes must not disturb the latched command.
        if (is_data) begin
          d_addr = ~addr; d_wdata = ~wdata; d_size = ~size; d_rw = ~rw;
        end else begin
          f_addr = ~addr;
        end
      end
      if (f_moc || d_moc) got = 1'b1;
    end
    if (!got) begin
      chk({tag, " moc timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, " latency"}, cyc, WS + 2);
      chk({tag, " ram_en cycles"}, en_cnt, WS + 1);
      check_pop(tag);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " hold moc"}, {31'd0, is_data ? d_moc : f_moc}, 32'd1);
      chk({tag, " hold no ram_en"}, {31'd0, ram_en}, 32'd0);
      if (rw) chk({tag, " hold rdata"}, is_data ? d_rdata : f_rdata, exp_rdata);
    end
    if (is_data) d_req = 1'b0; else f_req = 1'b0;
    @(negedge clk);
    chk({tag, " idle after release"}, {30'd0, busy, is_data ? d_moc : f_moc}, 32'd0);
  endtask

  initial begin
    bit got;
    int cyc;
    reset = 1'b0;
    f_req = 1'b0; f_addr = '0;
    d_req = 1'b0; d_rw = 1'b0; d_size = 2'b00; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[4] = 8'h04; mem[5] = 8'h40; mem[6] = 8'h86; mem[7] = 8'hE0;

    #1;
    chk("reset outputs", {26'd0, busy, ram_en, ram_rw, f_moc, d_moc, 1'b0}, 32'd0);
    chk("reset ram_addr", {24'd0, ram_addr}, 32'd0);
    chk("reset rdata", f_rdata | d_rdata | ram_wdata, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    access("fetch word", 1'b0, 1'b1, 2'b10, 8'h04, 32'h0, 8'h04, 32'h0, 32'hE0864004, 3);
    access("byte write", 1'b1, 1'b0, 2'b00, 8'h11, 32'hABCDEF5A, 8'h11, 32'h0000005A, 32'h0, 0);
    access("byte read", 1'b1, 1'b1, 2'b00, 8'h11, 32'h0, 8'h11, 32'h0, 32'h0000005A, 0);
    access("word read unaligned", 1'b1, 1'b1, 2'b10, 8'h07, 32'h0, 8'h04, 32'h0, 32'hE0864004, 0);
    access("word write held", 1'b1, 1'b0, 2'b10, 8'h20, 32'h12345678, 8'h20, 32'h12345678, 32'h0, 4);
    access("word readback", 1'b1, 1'b1, 2'b11, 8'h22, 32'h0, 8'h20, 32'h0, 32'h12345678, 0);

    // Simultaneous requests: data is served first, fetch afterwards.
    f_req = 1'b1; f_addr = 8'h04;
    d_req = 1'b1; d_rw = 1'b1; d_size = 2'b00; d_addr = 8'h11;
    sb.push_back('{1'b1, 1'b1, 32'h0000005A});
    sb.push_back('{1'b0, 1'b1, 32'hE0864004});
    wait_moc(BUDGET, got, cyc);
    if (!got) chk("collision first timeout", 32'd0, 32'd1);
    else check_pop("collision first");
    d_req = 1'b0;
    wait_moc(BUDGET, got, cyc);
    if (!got) chk("collision second timeout", 32'd0, 32'd1);
    else check_pop("collision second");
    f_req = 1'b0;
    @(negedge clk);
    chk("collision idle", {31'd0, busy}, 32'd0);

    // Request dropped mid-access: write still commits, moc pulses once.
    d_req = 1'b1; d_rw = 1'b0; d_size = 2'b10; d_addr = 8'h30; d_wdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("drop mid ram_en", {31'd0, ram_en}, 32'd1);
    d_req = 1'b0;
    wait_moc(BUDGET, got, cyc);
    chk("drop mid moc pulse", {31'd0, d_moc}, 32'd1);
    @(negedge clk);
    chk("drop mid moc falls", {30'd0, busy, d_moc}, 32'd0);
    access("dropped write readback", 1'b1, 1'b1, 2'b10, 8'h30, 32'h0, 8'h30, 32'h0, 32'hCAFEF00D, 0);

    // Reset in the second access cycle abandons the access; held req re-served.
    d_req = 1'b1; d_rw = 1'b1; d_size = 2'b10; d_addr = 8'h04;
    repeat (2) @(negedge clk);
    chk("pre-reset ram_en", {31'd0, ram_en}, 32'd1);
    reset = 1'b0;
    #1;
    chk("reset abandons access", {29'd0, ram_en, busy, d_moc}, 32'd0);
    @(negedge clk);
    chk("reset no moc", {30'd0, d_moc, f_moc}, 32'd0);
    reset = 1'b1;
    sb.push_back('{1'b1, 1'b1, 32'hE0864004});
    wait_moc(BUDGET, got, cyc);
    if (!got) chk("reserve timeout", 32'd0, 32'd1);
    else begin
      chk("reserve latency", cyc, WS + 2);
      check_pop("reserve");
    end
    d_req = 1'b0;
    @(negedge clk);
    chk("reserve idle", {31'd0, busy}, 32'd0);
    chk("scoreboard drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
